// File: rtl/exec_stage.sv
// Execute/writeback stage in front of a regbank: takes one instruction per handshake,
// runs a single-cycle ALU op or a 32-cycle shift-add multiply, and writes the result back.
module exec_stage #(
  parameter int unsigned CNT_W  = 16,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instr,
  output logic [4:0]       sr1,
  output logic [4:0]       sr2,
  input  logic [31:0]      rd_data1,
  input  logic [31:0]      rd_data2,
  output logic [4:0]       dr,
  output logic [31:0]      wrdata,
  output logic             write,
  output logic             busy,
  output logic [CNT_W-1:0] retired_count
);

  typedef enum logic [1:0] {StIdle, StExec, StMul, StWb} state_e;

  state_e             state_q;
  logic [3:0]         op_q;
  logic [4:0]         dst_q;
  logic [12:0]        imm_q;
  logic [31:0]        a_q, b_q;
  logic [31:0]        acc_q;
  logic [4:0]         mcnt_q;
  logic [4:0]         dr_q;
  logic [31:0]        wrdata_q;
  logic               write_q;
  logic [CNT_W-1:0]   retired_q;

  logic               accept;
  logic [31:0]        opa, opb;
  logic [31:0]        alu;
  logic [31:0]        acc_d;
  logic               is_mul;

  assign sr1           = instr[22:18];
  assign sr2           = instr[17:13];
  assign instr_ready   = (state_q == StIdle) || (state_q == StWb);
  assign busy          = (state_q != StIdle);
  assign accept        = instr_valid && instr_ready;
  assign is_mul        = MUL_EN && (instr[31:28] == 4'd9);
  assign dr            = dr_q;
  assign wrdata        = wrdata_q;
  assign write         = write_q;
  assign retired_count = retired_q;

  // Regbank write of the WB result lands on the same edge as this accept, so bypass it.
  always_comb begin
    opa = rd_data1;
    opb = rd_data2;
    if (state_q == StWb) begin
      if (sr1 == dr_q) opa = wrdata_q;
      if (sr2 == dr_q) opb = wrdata_q;
    end
  end

  always_comb begin
    alu = 32'd0;
    unique case (op_q)
      4'd0:    alu = a_q + b_q;
      4'd1:    alu = a_q - b_q;
      4'd2:    alu = a_q & b_q;
      4'd3:    alu = a_q | b_q;
      4'd4:    alu = a_q ^ b_q;
      4'd5:    alu = a_q << b_q[4:0];
      4'd6:    alu = a_q >> b_q[4:0];
      4'd7:    alu = {31'd0, $signed(a_q) < $signed(b_q)};
      4'd8:    alu = a_q + {{19{imm_q[12]}}, imm_q};
      default: alu = 32'd0;
    endcase
  end

  assign acc_d = acc_q + (b_q[0] ? a_q : 32'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      op_q      <= 4'd0;
      dst_q     <= 5'd0;
      imm_q     <= 13'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      acc_q     <= 32'd0;
      mcnt_q    <= 5'd0;
      dr_q      <= 5'd0;
      wrdata_q  <= 32'd0;
      write_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      write_q <= 1'b0;
      unique case (state_q)
        StIdle, StWb: begin
          if (state_q == StWb) retired_q <= retired_q + CNT_W'(1);
          if (accept) begin
            op_q    <= instr[31:28];
            dst_q   <= instr[27:23];
            imm_q   <= instr[12:0];
            a_q     <= opa;
            b_q     <= opb;
            acc_q   <= 32'd0;
            mcnt_q  <= 5'd0;
            state_q <= is_mul ? StMul : StExec;
          end else begin
            state_q <= StIdle;
          end
        end
        StExec: begin
          if (op_q <= 4'd8) begin
            wrdata_q <= alu;
            dr_q     <= dst_q;
            write_q  <= 1'b1;
            state_q  <= StWb;
          end else begin
            state_q <= StIdle;
          end
        end
        StMul: begin
          acc_q  <= acc_d;
          a_q    <= a_q << 1;
          b_q    <= b_q >> 1;
          mcnt_q <= mcnt_q + 5'd1;
          if (mcnt_q == 5'd31) begin
            wrdata_q <= acc_d;
            dr_q     <= dst_q;
            write_q  <= 1'b1;
            state_q  <= StWb;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// Bench for exec_stage: behavioural regbank, directed vector table, hand-written
// forwarding/reset sequences, and a randomized run against an architectural model.
module tb_exec_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        instr_ready;
  logic [4:0]  sr1, sr2, dr;
  logic [31:0] rd_data1, rd_data2, wrdata;
  logic        write, busy;
  logic [15:0] retired_count;

  exec_stage #(.CNT_W(16), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .sr1(sr1), .sr2(sr2), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .dr(dr), .wrdata(wrdata), .write(write), .busy(busy), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  // Regbank model: combinational reads, posedge writes, bulk reload to Rk = 20*k.
  logic [31:0] rf [32];
  logic        rf_load = 1'b1;
  assign rd_data1 = rf[sr1];
  assign rd_data2 = rf[sr2];
  always @(posedge clk) begin
    if (rf_load) begin
      for (int k = 0; k < 32; k++) rf[k] <= 32'(20 * k);
    end else if (write) begin
      rf[dr] <= wrdata;
    end
  end

  int tests = 0;
  int fails = 0;
  int exp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input int op, input int d, input int s1, input int s2,
                                      input int imm);
    logic [31:0] w;
    w = {4'(op), 5'(d), 5'(s1), 5'(s2), 13'(imm)};
    return w;
  endfunction

  // Architectural result of one instruction, straight from the op definitions.
  function automatic logic [31:0] ref_op(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [12:0] imm);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[4:0];
      4'd6: return a >> b[4:0];
      4'd7: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8: return a + 32'($signed(imm));
      4'd9: return a * b;
      default: return 32'd0;
    endcase
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic        exp_wr;
    logic [4:0]  exp_dr;
    logic [31:0] exp_data;
    int          exp_lat;
    int          exp_rdy_low;
  } vec_t;

  vec_t vecs [16];

  typedef struct {
    logic [4:0]  d;
    logic [31:0] v;
  } wr_t;

  wr_t         expq [$];
  logic [31:0] mrf  [32];

  // Issue one instruction from an idle stage and observe the following 40 cycles.
  task automatic run_vec(input vec_t v, input int idx);
    int n, wr_cnt, lat, rdy_low;
    logic [4:0]  got_dr;
    logic [31:0] got_data;
    n = 0;
    while (!instr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk($sformatf("v%0d_ready_timeout", idx), 32'(instr_ready), 32'd1);
    instr       = v.instr;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr       = $urandom;
    wr_cnt = 0; lat = -1; rdy_low = 0; got_dr = '0; got_data = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!instr_ready) rdy_low++;
      if (write) begin
        wr_cnt++;
        if (lat < 0) begin
          lat = k; got_dr = dr; got_data = wrdata;
        end
      end
    end
    chk($sformatf("v%0d_writes", idx), 32'(wr_cnt), 32'(v.exp_wr));
    if (v.exp_wr) begin
      chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
      chk($sformatf("v%0d_dr", idx), 32'(got_dr), 32'(v.exp_dr));
      chk($sformatf("v%0d_wrdata", idx), got_data, v.exp_data);
    end
    chk($sformatf("v%0d_ready_low_cycles", idx), 32'(rdy_low), 32'(v.exp_rdy_low));
    exp_cnt += int'(v.exp_wr);
    chk($sformatf("v%0d_count", idx), 32'(retired_count), 32'(exp_cnt));
  endtask

  initial begin
    int mism, issued, nwr, saw_wr;
    wr_t e;

    // Reset held: outputs pinned regardless of inputs.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      instr_valid = 1'($urandom);
      instr       = $urandom;
      #1;
      chk("rst_write", 32'(write), 32'd0);
      chk("rst_dr", 32'(dr), 32'd0);
      chk("rst_wrdata", wrdata, 32'd0);
      chk("rst_count", 32'(retired_count), 32'd0);
      chk("rst_ready", 32'(instr_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
    end
    @(negedge clk);
    instr_valid = 1'b0;
    rst = 1'b0;
    rf_load = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_ready", 32'(instr_ready), 32'd1);

    vecs[0]  = '{enc(0, 3, 1, 2, 0),       1'b1, 5'd3,  32'd60,       1,  1};
    vecs[1]  = '{enc(1, 3, 1, 2, 0),       1'b1, 5'd3,  32'hFFFFFFEC, 1,  1};
    vecs[2]  = '{enc(9, 5, 6, 7, 0),       1'b1, 5'd5,  32'd16800,    32, 32};
    vecs[3]  = '{enc(8, 8, 0, 0, 13'h1FFF), 1'b1, 5'd8, 32'hFFFFFFFF, 1,  1};
    vecs[4]  = '{enc(7, 9, 8, 1, 0),       1'b1, 5'd9,  32'd1,        1,  1};
    vecs[5]  = '{enc(6, 10, 8, 1, 0),      1'b1, 5'd10, 32'h00000FFF, 1,  1};
    vecs[6]  = '{enc(2, 11, 12, 13, 0),    1'b1, 5'd11, 32'd0,        1,  1};
    vecs[7]  = '{enc(3, 11, 12, 13, 0),    1'b1, 5'd11, 32'd500,      1,  1};
    vecs[8]  = '{enc(4, 14, 12, 13, 0),    1'b1, 5'd14, 32'd500,      1,  1};
    vecs[9]  = '{enc(5, 15, 1, 2, 0),      1'b1, 5'd15, 32'd5120,     1,  1};
    vecs[10] = '{enc(12, 21, 1, 2, 0),     1'b0, 5'd0,  32'd0,        0,  1};
    vecs[11] = '{enc(7, 16, 1, 8, 0),      1'b1, 5'd16, 32'd0,        1,  1};
    vecs[12] = '{enc(8, 17, 1, 0, 5),      1'b1, 5'd17, 32'd25,       1,  1};
    vecs[13] = '{enc(8, 18, 2, 0, 13'h1000), 1'b1, 5'd18, 32'hFFFFF028, 1, 1};
    vecs[14] = '{enc(9, 19, 8, 2, 0),      1'b1, 5'd19, 32'hFFFFFFD8, 32, 32};
    vecs[15] = '{enc(6, 20, 8, 2, 0),      1'b1, 5'd20, 32'h00FFFFFF, 1,  1};
    for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

    // Back-to-back SUB then ADD accepted in WB: r3 must be forwarded from wrdata.
    @(negedge clk);
    instr = enc(1, 3, 1, 2, 0);
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("fw_k0_write", 32'(write), 32'd0);
    instr = enc(0, 4, 3, 1, 0);
    @(negedge clk);
    chk("fw_k1_write", 32'(write), 32'd1);
    chk("fw_k1_dr", 32'(dr), 32'd3);
    chk("fw_k1_wrdata", wrdata, 32'hFFFFFFEC);
    chk("fw_k1_ready", 32'(instr_ready), 32'd1);
    @(negedge clk);
    instr_valid = 1'b0;
    chk("fw_k2_write", 32'(write), 32'd0);
    chk("fw_k2_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("fw_k3_write", 32'(write), 32'd1);
    chk("fw_k3_dr", 32'(dr), 32'd4);
    chk("fw_k3_wrdata", wrdata, 32'd0);
    @(negedge clk);
    exp_cnt += 2;
    chk("fw_count", 32'(retired_count), 32'(exp_cnt));

    // Reset during the 10th multiply cycle aborts the op without a write.
    @(negedge clk);
    instr = enc(9, 5, 6, 7, 0);
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    saw_wr = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (write) saw_wr++;
    end
    rst = 1'b1;
    rf_load = 1'b1;
    #1;
    chk("mulrst_write_before", 32'(saw_wr), 32'd0);
    chk("mulrst_write", 32'(write), 32'd0);
    chk("mulrst_ready", 32'(instr_ready), 32'd1);
    chk("mulrst_busy", 32'(busy), 32'd0);
    chk("mulrst_dr", 32'(dr), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rf_load = 1'b0;
    saw_wr = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (write) saw_wr++;
    end
    chk("mulrst_no_write_after", 32'(saw_wr), 32'd0);
    chk("mulrst_count", 32'(retired_count), 32'd0);
    chk("mulrst_ready_after", 32'(instr_ready), 32'd1);
    exp_cnt = 0;
    run_vec(vecs[10], 100);

    // Randomized run against the architectural model (register file in program order).
    for (int k = 0; k < 32; k++) mrf[k] = 32'(20 * k);
    issued = 0;
    nwr = 0;
    for (int c = 0; c < 6000 && issued < 300; c++) begin
      @(negedge clk);
      if (write) begin
        chk("rnd_write_expected", 32'(expq.size() > 0), 32'd1);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          chk("rnd_dr", 32'(dr), 32'(e.d));
          chk("rnd_wrdata", wrdata, e.v);
        end
      end
      if ($urandom_range(0, 3) != 0) begin
        instr_valid = 1'b1;
        instr = enc($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 7), $urandom_range(0, 8191));
      end else begin
        instr_valid = 1'b0;
      end
      #1;
      if (instr_valid && instr_ready) begin
        issued++;
        if (instr[31:28] <= 4'd9) begin
          e.v = ref_op(instr[31:28], mrf[instr[22:18]], mrf[instr[17:13]], instr[12:0]);
          e.d = instr[27:23];
          mrf[e.d] = e.v;
          expq.push_back(e);
          nwr++;
        end
      end
    end
    instr_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (write) begin
        chk("drain_write_expected", 32'(expq.size() > 0), 32'd1);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          chk("drain_dr", 32'(dr), 32'(e.d));
          chk("drain_wrdata", wrdata, e.v);
        end
      end
    end
    chk("rnd_issued", 32'(issued), 32'd300);
    chk("rnd_pending_writes", 32'(expq.size()), 32'd0);
    chk("rnd_count", 32'(retired_count), 32'(nwr % 65536));
    mism = 0;
    for (int k = 0; k < 32; k++) if (rf[k] !== mrf[k]) mism++;
    chk("rnd_regfile_mismatches", 32'(mism), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
